// File: rtl/count_uart_tx.sv
// Snapshot-to-UART bridge: on a rising snap_req, captures the upstream counter
// value and shifts it out as a single 8N1 frame (start, DATA_W bits LSB first, stop).
module count_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] count_in,
    input  logic              count_valid,
    input  logic              snap_req,
    input  logic              clr_overrun,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic              reject,
    output logic              overrun
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]        state;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic [CNT_W-1:0]  cyc_cnt;
    logic [BIT_W-1:0]  bit_idx;
    logic              snap_prev;
    logic              req_edge;
    logic              bit_end;

    assign req_edge   = snap_req & ~snap_prev;
    assign bit_end    = (cyc_cnt == CNT_LAST);
    assign shift_next = shift_reg >> 1;

    // tx is registered, so each bit transition loads the value of the *next* bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            cyc_cnt   <= '0;
            bit_idx   <= '0;
            // snap_prev starts high so a request held through reset is not an edge.
            snap_prev <= 1'b1;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            reject    <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below
            // sees the pre-edge values of state, shift_reg and the counters.
            snap_prev <= snap_req;
            done      <= 1'b0;
            reject    <= 1'b0;

            // Set has priority over clear when both land on the same edge.
            if (req_edge && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (req_edge) begin
                        if (count_valid) begin
                            shift_reg <= count_in;
                            state     <= S_START;
                            tx        <= 1'b0;
                            busy      <= 1'b1;
                            cyc_cnt   <= '0;
                        end else begin
                            reject <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        bit_idx <= '0;
                        state   <= S_DATA;
                        tx      <= shift_reg[0];
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cyc_cnt   <= '0;
                        shift_reg <= shift_next;
                        if (bit_idx == BIT_LAST) begin
                            state <= S_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shift_next[0];
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
